// File: rtl/cp0_regfile_v2.sv
// CP0 register file with Count/Compare timer, prescaler, hardware interrupt lines,
// and a req/ready access handshake with fixed latency.
module cp0_regfile_v2 #(
  parameter int INDEX_WIDTH = 5,
  parameter int NUM_HW_INT  = 6,
  parameter int COUNT_DIV   = 2,
  parameter int ACCESS_LAT  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_HW_INT-1:0] ext_int,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [4:0]            req_addr,
  input  logic [2:0]            req_sel,
  input  logic [31:0]           req_wdata,
  output logic                  req_ready,
  output logic [31:0]           rdata,
  input  logic                  exc_valid,
  input  logic [4:0]            exc_code,
  input  logic                  exc_bd,
  input  logic [31:0]           exc_epc,
  input  logic                  exc_badva_valid,
  input  logic [31:0]           exc_badvaddr,
  input  logic                  eret,
  output logic [31:0]           epc,
  output logic [31:0]           status,
  output logic [31:0]           cause,
  output logic                  int_pending,
  output logic                  timer_int
);

  localparam logic [INDEX_WIDTH-1:0] RAND_MAX  = {INDEX_WIDTH{1'b1}};
  localparam logic [3:0]             PRESC_MAX = 4'(COUNT_DIV - 1);
  localparam logic [1:0]             WAIT_MAX  = 2'(ACCESS_LAT - 2);

  localparam logic [4:0] REG_INDEX   = 5'd0;
  localparam logic [4:0] REG_RANDOM  = 5'd1;
  localparam logic [4:0] REG_WIRED   = 5'd6;
  localparam logic [4:0] REG_BADVA   = 5'd8;
  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       wait_q, wait_d;
  logic             rq_write_q, rq_write_d;
  logic [4:0]       rq_addr_q, rq_addr_d;
  logic [2:0]       rq_sel_q, rq_sel_d;
  logic [31:0]      rq_wdata_q, rq_wdata_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [INDEX_WIDTH-1:0] index_q, index_d;
  logic [INDEX_WIDTH-1:0] random_q, random_d;
  logic [INDEX_WIDTH-1:0] wired_q, wired_d;
  logic [31:0]      badva_q, badva_d;
  logic [31:0]      count_q, count_d;
  logic [3:0]       presc_q, presc_d;
  logic [31:0]      compare_q, compare_d;
  logic [31:0]      epc_q, epc_d;
  logic [7:0]       im_q, im_d;
  logic             exl_q, exl_d;
  logic             ie_q, ie_d;
  logic             bd_q, bd_d;
  logic             ti_q, ti_d;
  logic [4:0]       exccode_q, exccode_d;
  logic [1:0]       swip_q, swip_d;
  logic [5:0]       hw_q, hw_d;

  logic [4:0]       rd_addr_s;
  logic [2:0]       rd_sel_s;
  logic [31:0]      rd_data_s;
  logic [7:0]       ip_s;
  logic             wr_en_s;
  logic             count_upd_s;

  assign ip_s    = {hw_q[5] | ti_q, hw_q[4:0], swip_q};
  assign status  = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
  assign cause   = {bd_q, ti_q, 14'd0, ip_s, 1'b0, exccode_q, 2'b00};
  assign epc     = epc_q;
  assign timer_int   = ti_q;
  assign int_pending = ie_q & ~exl_q & (|(ip_s & im_q));
  assign req_ready   = (state_q == ST_DONE);
  assign rdata       = rdata_q;

  // An MTC0 only lands when no exception or ERET claims the same edge.
  assign wr_en_s = (state_q == ST_DONE) & rq_write_q & (rq_sel_q == 3'd0) & ~exc_valid & ~eret;

  // MFC0 read mux; uses live request fields when the access completes straight from IDLE.
  always_comb begin
    rd_data_s = 32'd0;
    if (state_q == ST_IDLE) begin
      rd_addr_s = req_addr;
      rd_sel_s  = req_sel;
    end else begin
      rd_addr_s = rq_addr_q;
      rd_sel_s  = rq_sel_q;
    end
    if (rd_sel_s == 3'd0) begin
      case (rd_addr_s)
        REG_INDEX:   rd_data_s = 32'(index_q);
        REG_RANDOM:  rd_data_s = 32'(random_q);
        REG_WIRED:   rd_data_s = 32'(wired_q);
        REG_BADVA:   rd_data_s = badva_q;
        REG_COUNT:   rd_data_s = count_q;
        REG_COMPARE: rd_data_s = compare_q;
        REG_STATUS:  rd_data_s = status;
        REG_CAUSE:   rd_data_s = cause;
        REG_EPC:     rd_data_s = epc_q;
        default:     rd_data_s = 32'd0;
      endcase
    end else begin
      rd_data_s = 32'd0;
    end
  end

  // Access handshake next-state logic.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    rq_write_d = rq_write_q;
    rq_addr_d  = rq_addr_q;
    rq_sel_d   = rq_sel_q;
    rq_wdata_d = rq_wdata_q;
    rdata_d    = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          rq_write_d = req_write;
          rq_addr_d  = req_addr;
          rq_sel_d   = req_sel;
          rq_wdata_d = req_wdata;
          wait_d     = 2'd0;
          if (ACCESS_LAT == 1) begin
            state_d = ST_DONE;
            if (!req_write) rdata_d = rd_data_s;
            else            rdata_d = rdata_q;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_q == WAIT_MAX) begin
          state_d = ST_DONE;
          if (!rq_write_q) rdata_d = rd_data_s;
          else             rdata_d = rdata_q;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Architectural register next-state logic.
  always_comb begin
    index_d   = index_q;
    random_d  = random_q;
    wired_d   = wired_q;
    badva_d   = badva_q;
    count_d   = count_q;
    presc_d   = presc_q;
    compare_d = compare_q;
    epc_d     = epc_q;
    im_d      = im_q;
    exl_d     = exl_q;
    ie_d      = ie_q;
    bd_d      = bd_q;
    ti_d      = ti_q;
    exccode_d = exccode_q;
    swip_d    = swip_q;
    hw_d      = 6'(ext_int);
    count_upd_s = 1'b0;

    if (wr_en_s && rq_addr_q == REG_COUNT) begin
      count_d     = rq_wdata_q;
      presc_d     = 4'd0;
      count_upd_s = 1'b1;
    end else if (presc_q == PRESC_MAX) begin
      count_d     = count_q + 32'd1;
      presc_d     = 4'd0;
      count_upd_s = 1'b1;
    end else begin
      presc_d = presc_q + 4'd1;
    end

    // A Compare write clears TI even if Count matches on the same edge.
    if (wr_en_s && rq_addr_q == REG_COMPARE) begin
      compare_d = rq_wdata_q;
      ti_d      = 1'b0;
    end else if (count_upd_s && (count_d == compare_q)) begin
      ti_d = 1'b1;
    end else begin
      ti_d = ti_q;
    end

    if (wr_en_s && rq_addr_q == REG_WIRED) begin
      random_d = RAND_MAX;
      wired_d  = rq_wdata_q[INDEX_WIDTH-1:0];
    end else if ((wired_q == RAND_MAX) || (random_q <= wired_q)) begin
      random_d = RAND_MAX;
    end else begin
      random_d = random_q - {{(INDEX_WIDTH-1){1'b0}}, 1'b1};
    end

    if (wr_en_s && rq_addr_q == REG_INDEX) index_d = rq_wdata_q[INDEX_WIDTH-1:0];
    else                                   index_d = index_q;

    if (exc_valid) begin
      exccode_d = exc_code;
      exl_d     = 1'b1;
      if (!exl_q) begin
        epc_d = exc_epc;
        bd_d  = exc_bd;
      end else begin
        epc_d = epc_q;
        bd_d  = bd_q;
      end
      if (exc_badva_valid) badva_d = exc_badvaddr;
      else                 badva_d = badva_q;
    end else if (eret) begin
      exl_d = 1'b0;
    end else begin
      if (wr_en_s && rq_addr_q == REG_STATUS) begin
        im_d  = rq_wdata_q[15:8];
        exl_d = rq_wdata_q[1];
        ie_d  = rq_wdata_q[0];
      end else begin
        im_d = im_q;
      end
      if (wr_en_s && rq_addr_q == REG_CAUSE) swip_d = rq_wdata_q[9:8];
      else                                   swip_d = swip_q;
      if (wr_en_s && rq_addr_q == REG_EPC)   epc_d = rq_wdata_q;
      else                                   epc_d = epc_q;
    end
  end

  // Handshake state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      wait_q     <= 2'd0;
      rq_write_q <= 1'b0;
      rq_addr_q  <= 5'd0;
      rq_sel_q   <= 3'd0;
      rq_wdata_q <= 32'd0;
      rdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      rq_write_q <= rq_write_d;
      rq_addr_q  <= rq_addr_d;
      rq_sel_q   <= rq_sel_d;
      rq_wdata_q <= rq_wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  // Architectural registers; Status resets with BEV set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      index_q   <= {INDEX_WIDTH{1'b0}};
      random_q  <= RAND_MAX;
      wired_q   <= {INDEX_WIDTH{1'b0}};
      badva_q   <= 32'd0;
      count_q   <= 32'd0;
      presc_q   <= 4'd0;
      compare_q <= 32'd0;
      epc_q     <= 32'd0;
      im_q      <= 8'd0;
      exl_q     <= 1'b0;
      ie_q      <= 1'b0;
      bd_q      <= 1'b0;
      ti_q      <= 1'b0;
      exccode_q <= 5'd0;
      swip_q    <= 2'd0;
      hw_q      <= 6'd0;
    end else begin
      index_q   <= index_d;
      random_q  <= random_d;
      wired_q   <= wired_d;
      badva_q   <= badva_d;
      count_q   <= count_d;
      presc_q   <= presc_d;
      compare_q <= compare_d;
      epc_q     <= epc_d;
      im_q      <= im_d;
      exl_q     <= exl_d;
      ie_q      <= ie_d;
      bd_q      <= bd_d;
      ti_q      <= ti_d;
      exccode_q <= exccode_d;
      swip_q    <= swip_d;
      hw_q      <= hw_d;
    end
  end

endmodule

// File: doc/cp0_regfile_v2.md
Name: cp0_regfile_v2

Overview:
- Parametrised next-generation CP0 register file for the MIPS core.
- Adds a Count/Compare timer interrupt, a configurable Count prescaler, a configurable number of level-sensitive hardware interrupt lines, and a computed interrupt-pending output.
- Replaces the implicit wen/ren ready scheme with an explicit req/ready access handshake with parametrised latency.
- Sits beside the memory stage: takes MTC0/MFC0 requests, exception and ERET events, and drives EPC/Status/Cause to the exception and fetch logic.

Parameters:
- INDEX_WIDTH, 5, TLB index width; TLB_SIZE = 2**INDEX_WIDTH.
- NUM_HW_INT, 6, number of hardware interrupt lines (1..6), mapped to Cause.IP[2+NUM_HW_INT-1:2].
- COUNT_DIV, 2, Count increments once every COUNT_DIV cycles (1..16).
- ACCESS_LAT, 2, cycles from request accept to req_ready (1..4).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- ext_int  in  NUM_HW_INT  hardware interrupt levels
- req_valid  in  1  CP0 access request, held until req_ready
- req_write  in  1  1 = MTC0, 0 = MFC0
- req_addr  in  5  register number
- req_sel  in  3  select
- req_wdata  in  32  MTC0 data
- req_ready  out  1  one-cycle completion pulse
- rdata  out  32  MFC0 data, valid while req_ready=1
- exc_valid  in  1  exception commit (single cycle)
- exc_code  in  5  ExcCode
- exc_bd  in  1  faulting instruction in delay slot
- exc_epc  in  32  EPC candidate
- exc_badva_valid  in  1  load BadVAddr
- exc_badvaddr  in  32  faulting address
- eret  in  1  ERET commit (single cycle)
- epc, status, cause  out  32 each  architectural values, combinational from the registers
- int_pending  out  1  interrupt to be taken
- timer_int  out  1  Cause.TI

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. On reset:
  - Status = 0x0040_0000 (BEV=1).
  - Random = TLB_SIZE-1.
  - All other registers = 0, including prescaler and FSM.
  - req_ready = 0, rdata = 0.
  - Reset mid-access aborts the access with no write committed.
- Implemented registers (sel 0): Index(0), Random(1), Wired(6), BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14).
  - Others read as 0; writes to them are ignored.
- Writable fields:
  - Index[INDEX_WIDTH-1:0] and Wired[INDEX_WIDTH-1:0].
  - Count, Compare and EPC: full 32 bits.
  - Status: IM[15:8], EXL[1], IE[0].
  - Cause: IP[9:8].
  - All other bits are read-only.
- Access FSM: IDLE -> WAIT (ACCESS_LAT-1 cycles) -> DONE -> IDLE.
  - A request is accepted in IDLE when req_valid=1.
  - DONE asserts req_ready for exactly one cycle.
  - MTC0 commits at the clock edge ending DONE.
  - MFC0 rdata is sampled entering DONE.
  - Back-to-back: a new request may be accepted the cycle after DONE.
  - Dropping req_valid mid-access is illegal; the block completes regardless.
- Exception (exc_valid=1), applied at the next edge:
  - Cause.ExcCode = exc_code; Status.EXL = 1.
  - If EXL was 0: EPC = exc_epc, Cause.BD = exc_bd. If EXL was already 1, EPC and BD hold.
  - If exc_badva_valid=1: BadVAddr = exc_badvaddr.
- ERET clears EXL.
- Priority: exc_valid > eret > committing MTC0.
  - A lost MTC0 is discarded, but req_ready still pulses.
- Count:
  - A prescaler counts 0..COUNT_DIV-1; Count increments when it reaches COUNT_DIV-1, wrapping 0xFFFF_FFFF -> 0.
  - MTC0 Count overrides the increment and clears the prescaler.
- Timer interrupt:
  - TI sets on the edge where the new Count equals Compare.
  - MTC0 Compare clears TI; when the clear coincides with a set, the clear wins.
- Cause.IP:
  - IP[2+i] = ext_int[i], registered every cycle, level-sensitive (not sticky).
  - IP7 = TI OR ext_int[5] when NUM_HW_INT=6.
  - Cause[30] = TI.
  - IP[1:0] are software-written.
- int_pending = Status.IE & ~Status.EXL & |(Cause.IP & Status.IM), combinational.
- Random:
  - Decrements every cycle. When Random <= Wired it reloads to TLB_SIZE-1.
  - MTC0 Wired reloads Random to TLB_SIZE-1.
  - If Wired >= TLB_SIZE-1, Random holds TLB_SIZE-1.

Test Plan:
- Reset, then MFC0 Status (12) -> req_ready pulses exactly ACCESS_LAT cycles after accept; rdata = 0x0040_0000; Random = 31.
- MTC0 Count=0x10, Compare=0x14, COUNT_DIV=2 -> TI and timer_int set 8 cycles after the Count write. Then Status = 0x0000_8001 -> int_pending=1. Then MTC0 Compare -> TI=0.
- MTC0 Count=0xFFFF_FFFF -> Count wraps to 0 after COUNT_DIV cycles; TI fires if Compare=0.
- exc_valid with epc=0xBFC0_0100, bd=1, code=4, badva=0x1234 -> EPC, BD=1, ExcCode=4, BadVAddr=0x1234, EXL=1. A second exception with epc=0x80 -> EPC unchanged, ExcCode updated. eret -> EXL=0.
- MTC0 EPC completing in the same cycle as exc_valid -> EPC = exc_epc; req_ready still pulses.
- MTC0 Wired=28 -> Random sequence 31, 30, 29, 28, 31, ...; ext_int[0] pulse for 1 cycle -> IP2 high for exactly 1 cycle, one cycle later.
